// File: rtl/romulus_ise_mc.sv
// Multi-cycle Romulus/SKINNY ISE unit: round step through a byte-serial S-box,
// plus single-cycle round-constant and tweakey-update helpers, per 32-bit lane.
module romulus_ise_mc #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned SBOX_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      imm,
    input  logic            op_rstep,
    input  logic            op_rc_upd,
    input  logic            op_rc_use_0,
    input  logic            op_rc_use_1,
    input  logic            op_tk_upd_0,
    input  logic            op_tk_upd_1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rd
);

    localparam int unsigned LANES  = XLEN / 32;
    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned NSTEPS = NBYTES / SBOX_PER_CYCLE;
    localparam int unsigned CW     = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {StIdle, StSbox, StFin, StResp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] sw_q, sw_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [2:0]      imm_q, imm_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic [XLEN-1:0] direct;
    logic [5:0]      ops;

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        logic [7:0] b;
        b = x;
        for (int r = 0; r < 4; r++) begin
            b[0] = b[0] ^ ~(b[2] | b[3]);
            b[4] = b[4] ^ ~(b[6] | b[7]);
            if (r < 3) b = {b[2], b[1], b[7], b[6], b[4], b[0], b[3], b[5]};
            else       b = {b[7], b[6], b[5], b[4], b[3], b[1], b[2], b[0]};
        end
        return b;
    endfunction

    function automatic logic [31:0] fin_lane(input logic [31:0] sr, input logic [31:0] k,
                                             input logic [2:0] im);
        logic [31:0] r;
        if (im == 3'd2)      r = sr ^ 32'h0000_0002;
        else if (im == 3'd3) r = sr;
        else                 r = sr ^ k;
        case (im)
            3'd1:    return {r[23:0], r[31:24]};
            3'd2:    return {r[15:0], r[31:16]};
            3'd3:    return {r[7:0], r[31:8]};
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] tk_lane(input logic [31:0] tt, input logic [2:0] im);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            case (im)
                3'd1:    r[8*k +: 8] = tt[8*k +: 8];
                3'd2:    r[8*k +: 8] = {tt[8*k +: 7], tt[8*k+7] ^ tt[8*k+5]};
                3'd3:    r[8*k +: 8] = {tt[8*k+6] ^ tt[8*k], tt[8*k+1 +: 7]};
                default: r[8*k +: 8] = 8'h00;
            endcase
        end
        return r;
    endfunction

    assign ops = {op_rstep, op_rc_upd, op_rc_use_0, op_rc_use_1, op_tk_upd_0, op_tk_upd_1};

    // Single-cycle ops; anything not exactly one-hot (incl. rstep mixed with others) yields 0.
    always_comb begin
        logic [31:0] a, b;
        direct = '0;
        for (int l = 0; l < LANES; l++) begin
            a = rs1[32*l +: 32];
            b = rs2[32*l +: 32];
            case (ops)
                6'b010000: direct[32*l +: 32] = (l == 0) ?
                               {24'h0, 2'b00, a[4:0], a[5] ^ a[4] ^ 1'b1} : 32'h0;
                6'b001000: direct[32*l +: 32] = {b[31:4], b[3:0] ^ a[3:0]};
                6'b000100: direct[32*l +: 32] = {b[31:2], b[1:0] ^ a[5:4]};
                6'b000010: direct[32*l +: 32] =
                               tk_lane({b[15:8], a[7:0], b[31:24], a[15:8]}, imm);
                6'b000001: direct[32*l +: 32] =
                               tk_lane({a[31:24], b[7:0], b[23:16], a[23:16]}, imm);
                default:   direct[32*l +: 32] = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rs2_d = rs2;
                    imm_d = imm;
                    if (ops == 6'b100000) begin
                        sw_d    = rs1;
                        cnt_d   = '0;
                        state_d = StSbox;
                    end else begin
                        rd_d    = direct;
                        state_d = StResp;
                    end
                end
            end
            StSbox: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (i / SBOX_PER_CYCLE == int'(cnt_q)) sw_d[8*i +: 8] = sbox8(sw_q[8*i +: 8]);
                end
                if (cnt_q == CW'(NSTEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFin: begin
                for (int l = 0; l < LANES; l++) begin
                    rd_d[32*l +: 32] = fin_lane(sw_q[32*l +: 32], rs2_q[32*l +: 32], imm_q);
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sw_q    <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_romulus_ise_mc.sv
// Bench for romulus_ise_mc: a 32-bit/1-byte and a 64-bit/4-byte instance driven in lockstep.
module tb_romulus_ise_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic [2:0]  imm = '0;
    logic        op_rstep = 0, op_rc_upd = 0, op_rc_use_0 = 0, op_rc_use_1 = 0;
    logic        op_tk_upd_0 = 0, op_tk_upd_1 = 0;
    logic        req_ready32, rsp_valid32, req_ready64, rsp_valid64;
    logic [31:0] rd32;
    logic [63:0] rd64;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    romulus_ise_mc #(.XLEN(32), .SBOX_PER_CYCLE(1)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready32),
        .rs1(rs1[31:0]), .rs2(rs2[31:0]), .imm(imm),
        .op_rstep(op_rstep), .op_rc_upd(op_rc_upd), .op_rc_use_0(op_rc_use_0),
        .op_rc_use_1(op_rc_use_1), .op_tk_upd_0(op_tk_upd_0), .op_tk_upd_1(op_tk_upd_1),
        .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready), .rd(rd32)
    );

    romulus_ise_mc #(.XLEN(64), .SBOX_PER_CYCLE(4)) u64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready64),
        .rs1(rs1), .rs2(rs2), .imm(imm),
        .op_rstep(op_rstep), .op_rc_upd(op_rc_upd), .op_rc_use_0(op_rc_use_0),
        .op_rc_use_1(op_rc_use_1), .op_tk_upd_0(op_tk_upd_0), .op_tk_upd_1(op_tk_upd_1),
        .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready), .rd(rd64)
    );

    typedef struct {
        logic [5:0]  ops;
        logic [2:0]  imm;
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference S-box: four rounds of NOR-feedback followed by bit-position tables.
    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        int mid[8];
        int fin[8];
        logic [7:0] b, n;
        mid = '{5, 3, 0, 4, 6, 7, 1, 2};
        fin = '{0, 2, 1, 3, 4, 5, 6, 7};
        b = x;
        for (int r = 1; r <= 4; r++) begin
            if (!(b[2] || b[3])) b[0] = !b[0];
            if (!(b[6] || b[7])) b[4] = !b[4];
            for (int k = 0; k < 8; k++) n[k] = (r < 4) ? b[mid[k]] : b[fin[k]];
            b = n;
        end
        return b;
    endfunction

    function automatic logic [31:0] tk_ref(input logic [31:0] tt, input logic [2:0] im);
        logic [31:0] r;
        logic [7:0]  v;
        r = '0;
        if (im == 3'd1) return tt;
        for (int k = 0; k < 4; k++) begin
            v = tt[8*k +: 8];
            if (im == 3'd2)      r[8*k +: 8] = ((v << 1) & 8'hFE) | (((v >> 7) ^ (v >> 5)) & 8'h01);
            else if (im == 3'd3) r[8*k +: 8] = (v >> 1) | ((((v >> 6) ^ v) & 8'h01) << 7);
        end
        return r;
    endfunction

    function automatic logic [63:0] model(input logic [5:0] ops, input logic [2:0] im,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input int lanes);
        logic [63:0] res;
        logic [31:0] x, y, r, tt;
        res = '0;
        for (int l = 0; l < lanes; l++) begin
            x = a[32*l +: 32];
            y = b[32*l +: 32];
            r = '0;
            case (ops)
                6'b100000: begin
                    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_sbox(x[8*k +: 8]);
                    if (im == 3'd2) r = r ^ 32'd2;
                    else if (im != 3'd3) r = r ^ y;
                    if (im >= 3'd1 && im <= 3'd3) r = (r << (8 * im)) | (r >> (32 - 8 * im));
                end
                6'b010000: if (l == 0) r = (32'(x[4:0]) << 1) | 32'(x[5] ^ x[4] ^ 1'b1);
                6'b001000: r = y ^ (x & 32'hF);
                6'b000100: r = y ^ ((x >> 4) & 32'h3);
                6'b000010: begin
                    tt = {y[15:8], x[7:0], y[31:24], x[15:8]};
                    r  = tk_ref(tt, im);
                end
                6'b000001: begin
                    tt = {x[31:24], y[7:0], y[23:16], x[23:16]};
                    r  = tk_ref(tt, im);
                end
                default: r = '0;
            endcase
            res[32*l +: 32] = r;
        end
        return res;
    endfunction

    task automatic drive(input logic [5:0] ops, input logic [2:0] im,
                         input logic [63:0] a, input logic [63:0] b);
        {op_rstep, op_rc_upd, op_rc_use_0, op_rc_use_1, op_tk_upd_0, op_tk_upd_1} = ops;
        imm = im;
        rs1 = a;
        rs2 = b;
    endtask

    task automatic scramble();
        drive(6'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic do_txn(input string nm, input logic [5:0] ops, input logic [2:0] im,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [31:0] e32, input logic [63:0] e64);
        int l32, l64, x32, x64;
        x32 = (ops == 6'b100000) ? 6 : 1;
        x64 = (ops == 6'b100000) ? 4 : 1;
        chk({nm, "_ready"}, 64'({req_ready32, req_ready64}), 64'h3);
        drive(ops, im, a, b);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        l32 = 0;
        l64 = 0;
        for (int c = 1; c <= 20 && (l32 == 0 || l64 == 0); c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (l32 == 0 && rsp_valid32) l32 = c;
            if (l64 == 0 && rsp_valid64) l64 = c;
        end
        chk({nm, "_lat32"}, 64'(l32), 64'(x32));
        chk({nm, "_lat64"}, 64'(l64), 64'(x64));
        chk({nm, "_rd32"}, 64'(rd32), 64'(e32));
        chk({nm, "_rd64"}, rd64, e64);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, "_release"}, 64'({rsp_valid32, rsp_valid64}), 64'h0);
    endtask

    initial begin
        logic [5:0]  ops;
        logic [2:0]  im;
        logic [63:0] a, b;
        int          seen;
        int          r;

        tbl[0]  = '{6'b100000, 3'd3, 64'h0, 64'h0, 32'h65656565, 64'h6565656565656565};
        tbl[1]  = '{6'b010000, 3'd0, 64'h1, 64'h0, 32'h00000003, 64'h0000000000000003};
        tbl[2]  = '{6'b000010, 3'd1, 64'h33221100, 64'h77665544, 32'h55007711, 64'h55007711};
        tbl[3]  = '{6'b000010, 3'd5, 64'h33221100, 64'h77665544, 32'h0, 64'h0};
        tbl[4]  = '{6'b000001, 3'd2, 64'h01010000, 64'h00010001, 32'h02020202, 64'h02020202};
        tbl[5]  = '{6'b000001, 3'd3, 64'h01010000, 64'h00010001, 32'h80808080, 64'h80808080};
        tbl[6]  = '{6'b100000, 3'd0, 64'hFFFFFFFF_00000000, 64'h0, 32'h65656565,
                    64'hFFFFFFFF_65656565};
        tbl[7]  = '{6'b000000, 3'd1, 64'h1234, 64'h5678, 32'h0, 64'h0};
        tbl[8]  = '{6'b110000, 3'd1, 64'h1, 64'h5678, 32'h0, 64'h0};
        tbl[9]  = '{6'b001000, 3'd0, 64'hF, 64'h12345678, 32'h12345677, 64'h12345677};
        tbl[10] = '{6'b000100, 3'd0, 64'h30, 64'hABCDEF00, 32'hABCDEF03, 64'hABCDEF03};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd32", 64'(rd32), 64'h0);
        chk("reset_rd64", rd64, 64'h0);
        chk("reset_flags", 64'({req_ready32, req_ready64, rsp_valid32, rsp_valid64}), 64'hC);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].ops, tbl[i].imm, tbl[i].a, tbl[i].b,
                   tbl[i].e32, tbl[i].e64);
        end

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 7));
            if (r < 6)       ops = 6'(1 << r);
            else if (r == 6) ops = 6'($urandom);
            else             ops = 6'b100000;
            im = 3'($urandom);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            do_txn($sformatf("rnd%0d", i), ops, im, a, b,
                   model(ops, im, a, b, 1) & 64'hFFFFFFFF, model(ops, im, a, b, 2));
        end

        // Response held off for 10 cycles while another request is being offered.
        drive(6'b010000, 3'd0, 64'h1, 64'h0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        drive(6'b000010, 3'd1, 64'h33221100, 64'h77665544);
        for (int c = 0; c < 10; c++) begin
            chk("hold_rd32", 64'(rd32), 64'h3);
            chk("hold_rd64", rd64, 64'h3);
            chk("hold_flags", 64'({req_ready32, req_ready64, rsp_valid32, rsp_valid64}), 64'h3);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("release_no_accept",
            64'({req_ready32, req_ready64, rsp_valid32, rsp_valid64}), 64'hC);
        @(posedge clk); #1;
        chk("release_idle", 64'({rsp_valid32, rsp_valid64}), 64'h0);

        // Reset while both instances are in the middle of the S-box phase.
        drive(6'b100000, 3'd0, {$urandom, $urandom}, {$urandom, $urandom});
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 64'({req_ready32, req_ready64}), 64'h3);
        chk("midrst_rd32", 64'(rd32), 64'h0);
        chk("midrst_rd64", rd64, 64'h0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid32 || rsp_valid64) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_rsp", 64'(seen), 64'h0);

        do_txn("post_rst", 6'b100000, 3'd3, 64'h0, 64'h0, 32'h65656565, 64'h6565656565656565);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
